// File: rtl/header_inserter.sv
// header_inserter: prepends a HEADER_BYTES header to every packet on a sop/eop/empty stream,
// realigning payload across beats. Optional per-packet bypass port: HEADER_INSERTER_BYPASS_EN.
module header_inserter #(
  parameter int DATA_WIDTH   = 128,
  parameter int HEADER_BYTES = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [8*HEADER_BYTES-1:0]       header_data,
  input  logic [DATA_WIDTH-1:0]           data_in_data,
  input  logic                            data_in_valid,
  input  logic                            data_in_sop,
  input  logic                            data_in_eop,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] data_in_empty,
  output logic                            data_in_ready,
  output logic [DATA_WIDTH-1:0]           data_out_data,
  output logic                            data_out_valid,
  output logic                            data_out_sop,
  output logic                            data_out_eop,
  output logic [$clog2(DATA_WIDTH/8)-1:0] data_out_empty,
  input  logic                            data_out_ready,
  output logic                            err_drop
`ifdef HEADER_INSERTER_BYPASS_EN
  ,
  input  logic                            bypass
`endif
);

  localparam int W    = DATA_WIDTH / 8;
  localparam int EW   = $clog2(W);
  localparam int HB   = HEADER_BYTES / W;
  localparam int R    = HEADER_BYTES % W;
  localparam int RW   = (R > 0) ? R : 1;
  localparam int CW   = ($clog2(HB + 1) > 8) ? $clog2(HB + 1) : 8;
  localparam int PADW = (HB + 1) * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_HDR = CW'((HB > 0) ? HB - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] BODY = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;

  // Header beat k, with the partial last beat padded so every slice stays in range.
  function automatic logic [DATA_WIDTH-1:0] hdr_beat(input logic [8*HEADER_BYTES-1:0] h,
                                                     input logic [CW-1:0] k);
    logic [PADW-1:0] p;
    p = {h, {(PADW - 8*HEADER_BYTES){1'b0}}} << (DATA_WIDTH * int'(k));
    return p[PADW-1 -: DATA_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] realign(input logic [8*RW-1:0] res,
                                                    input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] hi;
    hi = {{(DATA_WIDTH - 8*RW){1'b0}}, res} << (DATA_WIDTH - 8*RW);
    return hi | (d >> (8*RW));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] keep_bytes(input logic [DATA_WIDTH-1:0] d,
                                                       input int n);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (i < n) r[DATA_WIDTH-1-8*i -: 8] = d[DATA_WIDTH-1-8*i -: 8];
    end
    return r;
  endfunction

  logic [1:0]                state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [8*HEADER_BYTES-1:0] hdr_reg, hdr_next;
  logic [8*RW-1:0]           residue_reg, residue_next;
  logic [EW-1:0]             tail_empty_reg, tail_empty_next;
  logic                      byp_reg, byp_next, byp_in;

  logic [DATA_WIDTH-1:0]     out_data_reg;
  logic                      out_valid_reg, out_sop_reg, out_eop_reg, err_drop_reg;
  logic [EW-1:0]             out_empty_reg;

  logic                      load, pass, consume, emit, drop, in_ready;
  logic [DATA_WIDTH-1:0]     aligned, b_data, o_data;
  logic [8*RW-1:0]           res_src;
  logic                      b_eop, b_tail, o_sop, o_eop;
  logic [EW-1:0]             b_empty, o_empty;
  int                        v_bytes;

`ifdef HEADER_INSERTER_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  assign load = !out_valid_reg || data_out_ready;

  // Payload beat formatting, shared by the IDLE (HB=0 / bypass) path and BODY.
  always_comb begin
    v_bytes = W - int'(data_in_empty);
    pass    = (R == 0) || ((state_reg == IDLE) ? byp_in : byp_reg);
    res_src = (state_reg == IDLE) ? header_data[8*RW-1:0] : residue_reg;
    aligned = pass ? data_in_data : realign(res_src, data_in_data);
    b_data  = aligned;
    b_eop   = 1'b0;
    b_empty = '0;
    b_tail  = 1'b0;
    if (data_in_eop) begin
      if (pass) begin
        b_data  = keep_bytes(data_in_data, v_bytes);
        b_eop   = 1'b1;
        b_empty = data_in_empty;
      end else if (R + v_bytes <= W) begin
        b_data  = keep_bytes(aligned, R + v_bytes);
        b_eop   = 1'b1;
        b_empty = EW'(W - R - v_bytes);
      end else begin
        b_tail = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    hdr_next        = hdr_reg;
    residue_next    = residue_reg;
    tail_empty_next = tail_empty_reg;
    byp_next        = byp_reg;
    emit            = 1'b0;
    o_data          = '0;
    o_sop           = 1'b0;
    o_eop           = 1'b0;
    o_empty         = '0;
    in_ready        = 1'b0;
    drop            = 1'b0;
    consume         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (data_in_valid && !data_in_sop) begin
          in_ready = 1'b1;
          drop     = 1'b1;
        end else if (data_in_valid && load) begin
          hdr_next = header_data;
          byp_next = byp_in;
          if (byp_in || HB == 0) begin
            consume = 1'b1;
          end else begin
            emit         = 1'b1;
            o_data       = hdr_beat(header_data, '0);
            o_sop        = 1'b1;
            cnt_next     = CW'(1);
            residue_next = header_data[8*RW-1:0];
            state_next   = (HB == 1) ? BODY : HDR;
          end
        end
      end
      HDR: begin
        if (load) begin
          emit   = 1'b1;
          o_data = hdr_beat(hdr_reg, cnt_reg);
          if (cnt_reg == LAST_HDR) state_next = BODY;
          else cnt_next = cnt_reg + CW'(1);
        end
      end
      BODY: begin
        in_ready = load;
        if (load && data_in_valid) consume = 1'b1;
      end
      default: begin
        if (load) begin
          emit       = 1'b1;
          o_data     = keep_bytes(realign(residue_reg, '0), W - int'(tail_empty_reg));
          o_eop      = 1'b1;
          o_empty    = tail_empty_reg;
          state_next = IDLE;
        end
      end
    endcase

    if (consume) begin
      in_ready        = 1'b1;
      emit            = 1'b1;
      o_data          = b_data;
      o_sop           = (state_reg == IDLE);
      o_eop           = b_eop;
      o_empty         = b_empty;
      residue_next    = data_in_data[8*RW-1:0];
      tail_empty_next = EW'(2*W - R - v_bytes);
      state_next      = b_tail ? TAIL : (data_in_eop ? IDLE : BODY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      hdr_reg        <= '0;
      residue_reg    <= '0;
      tail_empty_reg <= '0;
      byp_reg        <= 1'b0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_sop_reg    <= 1'b0;
      out_eop_reg    <= 1'b0;
      out_empty_reg  <= '0;
      err_drop_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      hdr_reg        <= hdr_next;
      residue_reg    <= residue_next;
      tail_empty_reg <= tail_empty_next;
      byp_reg        <= byp_next;
      err_drop_reg   <= drop;
      if (load) begin
        out_valid_reg <= emit;
        out_data_reg  <= o_data;
        out_sop_reg   <= o_sop;
        out_eop_reg   <= o_eop;
        out_empty_reg <= o_empty;
      end
    end
  end

  assign data_in_ready  = in_ready;
  assign data_out_data  = out_data_reg;
  assign data_out_valid = out_valid_reg;
  assign data_out_sop   = out_sop_reg;
  assign data_out_eop   = out_eop_reg;
  assign data_out_empty = out_empty_reg;
  assign err_drop       = err_drop_reg;

endmodule
